// File: rtl/combi_response_checker.sv
// combi_response_checker
// Checks the output y of a 3-input combinational circuit against a
// parameterised truth table. One vector is accepted per check. y is sampled
// a fixed number of cycles after acceptance. The block keeps saturating
// check and error counters and a record of the first failing vector.
module combi_response_checker #(
  parameter logic [7:0]  EXPECTED = 8'b1111_0010,
  parameter int unsigned SETTLE   = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             vec_valid,
  input  logic [2:0]       vec_abc,
  output logic             vec_ready,
  input  logic             y_in,
  output logic             check_done,
  output logic             check_pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_abc,
  output logic             first_err_y
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // The settle counter is loaded with SETTLE-1 so that y is sampled exactly
  // SETTLE edges after the accepting edge.
  localparam logic [7:0]       LP_SETTLE_LOAD = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LP_CNT_ONE     = CNT_W'(1);

  state_t           r_state;
  logic             r_ready;
  logic [7:0]       r_cnt;
  logic [2:0]       r_abc;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_chk;
  logic [CNT_W-1:0] r_err;
  logic             r_fev;
  logic [2:0]       r_fabc;
  logic             r_fy;

  logic             w_accept;
  logic             w_match;
  logic             w_chk_sat;
  logic             w_err_sat;

  // A vector presented alongside clear is never accepted.
  assign w_accept  = vec_valid & r_ready & ~clear;
  assign w_match   = (y_in == EXPECTED[r_abc]);
  assign w_chk_sat = (r_chk == LP_CNT_MAX);
  assign w_err_sat = (r_err == LP_CNT_MAX);

  // Check sequencer: accepts a vector, waits the settle time, then compares
  // the sampled y and updates the counters and the first-error record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_cnt   <= 8'd0;
      r_abc   <= 3'b000;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_chk   <= '0;
      r_err   <= '0;
      r_fev   <= 1'b0;
      r_fabc  <= 3'b000;
      r_fy    <= 1'b0;
    end else if (clear) begin
      // clear aborts any in-flight check and discards a coinciding result.
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_cnt   <= 8'd0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_chk   <= '0;
      r_err   <= '0;
      r_fev   <= 1'b0;
      r_fabc  <= 3'b000;
      r_fy    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_pass <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_abc   <= vec_abc;
            r_cnt   <= LP_SETTLE_LOAD;
            r_state <= S_WAIT;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt == 8'd0) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_pass  <= w_match;
            if (!w_chk_sat) begin
              r_chk <= r_chk + LP_CNT_ONE;
            end else begin
              r_chk <= r_chk;
            end
            // err never passes chk because both saturate at the same value
            // and err only moves when chk moves or is already saturated.
            if (!w_match && !w_err_sat) begin
              r_err <= r_err + LP_CNT_ONE;
            end else begin
              r_err <= r_err;
            end
            if (!w_match && !r_fev) begin
              r_fev  <= 1'b1;
              r_fabc <= r_abc;
              r_fy   <= y_in;
            end else begin
              r_fev  <= r_fev;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign vec_ready       = r_ready;
  assign check_done      = r_done;
  assign check_pass      = r_pass;
  assign chk_count       = r_chk;
  assign err_count       = r_err;
  assign first_err_valid = r_fev;
  assign first_err_abc   = r_fabc;
  assign first_err_y     = r_fy;

endmodule

// File: tb/tb_combi_response_checker.sv
// Directed bench for combi_response_checker: one DUT with default parameters
// and a second with CNT_W=2 for the saturation case.
module tb_combi_response_checker;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       vec_valid;
  logic [2:0] vec_abc;
  logic       vec_ready;
  logic       y_in;
  logic       check_done;
  logic       check_pass;
  logic [7:0] chk_count;
  logic [7:0] err_count;
  logic       first_err_valid;
  logic [2:0] first_err_abc;
  logic       first_err_y;

  logic       d2_clear;
  logic       d2_valid;
  logic [2:0] d2_abc;
  logic       d2_ready;
  logic       d2_y;
  logic       d2_done;
  logic       d2_pass;
  logic [1:0] d2_chk;
  logic [1:0] d2_err;
  logic       d2_fev;
  logic [2:0] d2_fabc;
  logic       d2_fy;

  int n_checks;
  int n_errors;

  combi_response_checker u_dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .vec_valid       (vec_valid),
    .vec_abc         (vec_abc),
    .vec_ready       (vec_ready),
    .y_in            (y_in),
    .check_done      (check_done),
    .check_pass      (check_pass),
    .chk_count       (chk_count),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_abc   (first_err_abc),
    .first_err_y     (first_err_y)
  );

  combi_response_checker #(.CNT_W(2)) u_dut2 (
    .clk             (clk),
    .rst             (rst),
    .clear           (d2_clear),
    .vec_valid       (d2_valid),
    .vec_abc         (d2_abc),
    .vec_ready       (d2_ready),
    .y_in            (d2_y),
    .check_done      (d2_done),
    .check_pass      (d2_pass),
    .chk_count       (d2_chk),
    .err_count       (d2_err),
    .first_err_valid (d2_fev),
    .first_err_abc   (d2_fabc),
    .first_err_y     (d2_fy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one vector with y held, and checks the exact settle latency
  // (SETTLE=4) and the reported result.
  task automatic run_vec(input logic [2:0] abc, input logic y, input logic exp_pass);
    check("ready_before", 32'(vec_ready), 32'd1);
    vec_valid = 1'b1;
    vec_abc   = abc;
    y_in      = y;
    tick();
    vec_valid = 1'b0;
    check("ready_wait", 32'(vec_ready), 32'd0);
    repeat (3) tick();
    check("done_early", 32'(check_done), 32'd0);
    check("ready_late_wait", 32'(vec_ready), 32'd0);
    tick();
    check("done_pulse", 32'(check_done), 32'd1);
    check("pass_value", 32'(check_pass), 32'(exp_pass));
    check("ready_after", 32'(vec_ready), 32'd1);
  endtask

  initial begin
    int seen_done;
    int d2_pulses;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    vec_valid = 1'b0;
    vec_abc   = 3'b000;
    y_in      = 1'b0;
    d2_clear  = 1'b0;
    d2_valid  = 1'b0;
    d2_abc    = 3'b000;
    d2_y      = 1'b0;

    // Reset state
    #2;
    check("rst_ready", 32'(vec_ready), 32'd1);
    check("rst_done", 32'(check_done), 32'd0);
    check("rst_chk", 32'(chk_count), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_fev", 32'(first_err_valid), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Passing vectors, back to back: EXPECTED bits 0,1,4,6 = 0,1,1,1
    run_vec(3'b000, 1'b0, 1'b1);
    run_vec(3'b001, 1'b1, 1'b1);
    run_vec(3'b100, 1'b1, 1'b1);
    run_vec(3'b110, 1'b1, 1'b1);
    check("pass_chk4", 32'(chk_count), 32'd4);
    check("pass_err0", 32'(err_count), 32'd0);
    check("pass_fev0", 32'(first_err_valid), 32'd0);
    tick();
    check("done_one_cycle", 32'(check_done), 32'd0);
    check("pass_zero_idle", 32'(check_pass), 32'd0);

    // Two failures; the first one is recorded and kept
    run_vec(3'b100, 1'b0, 1'b0);
    check("fe_valid1", 32'(first_err_valid), 32'd1);
    check("fe_abc1", 32'(first_err_abc), 32'd4);
    check("fe_y1", 32'(first_err_y), 32'd0);
    run_vec(3'b000, 1'b1, 1'b0);
    check("fail_chk6", 32'(chk_count), 32'd6);
    check("fail_err2", 32'(err_count), 32'd2);
    check("fe_valid2", 32'(first_err_valid), 32'd1);
    check("fe_abc_kept", 32'(first_err_abc), 32'd4);
    check("fe_y_kept", 32'(first_err_y), 32'd0);

    // clear two edges after acceptance, with vec_valid held alongside clear
    vec_valid = 1'b1;
    vec_abc   = 3'b011;
    y_in      = 1'b1;
    tick();
    vec_valid = 1'b0;
    tick();
    clear     = 1'b1;
    vec_valid = 1'b1;
    tick();
    clear     = 1'b0;
    check("clr_ready", 32'(vec_ready), 32'd1);
    check("clr_done", 32'(check_done), 32'd0);
    check("clr_chk", 32'(chk_count), 32'd0);
    check("clr_err", 32'(err_count), 32'd0);
    check("clr_fev", 32'(first_err_valid), 32'd0);
    check("clr_fabc", 32'(first_err_abc), 32'd0);
    vec_valid = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (check_done) seen_done++;
    end
    check("clr_no_done", 32'(seen_done), 32'd0);

    // clear on the sampling edge of a failing check discards the result
    vec_valid = 1'b1;
    vec_abc   = 3'b010;
    y_in      = 1'b1;
    tick();
    vec_valid = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clrs_done", 32'(check_done), 32'd0);
    check("clrs_chk", 32'(chk_count), 32'd0);
    check("clrs_err", 32'(err_count), 32'd0);
    check("clrs_fev", 32'(first_err_valid), 32'd0);
    check("clrs_ready", 32'(vec_ready), 32'd1);

    // CNT_W=2: five failing checks saturate both counters at 3
    d2_valid  = 1'b1;
    d2_abc    = 3'b011;
    d2_y      = 1'b1;
    d2_pulses = 0;
    for (int i = 0; i < 40 && d2_pulses < 5; i++) begin
      tick();
      if (d2_done) d2_pulses++;
    end
    d2_valid = 1'b0;
    check("sat_pulses", 32'(d2_pulses), 32'd5);
    check("sat_chk", 32'(d2_chk), 32'd3);
    check("sat_err", 32'(d2_err), 32'd3);
    check("sat_fev", 32'(d2_fev), 32'd1);
    check("sat_fabc", 32'(d2_fabc), 32'd3);
    check("sat_fy", 32'(d2_fy), 32'd1);
    tick();

    // Asynchronous reset between edges while a check is in flight
    run_vec(3'b100, 1'b0, 1'b0);
    vec_valid = 1'b1;
    vec_abc   = 3'b001;
    y_in      = 1'b0;
    tick();
    vec_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", 32'(vec_ready), 32'd1);
    check("arst_done", 32'(check_done), 32'd0);
    check("arst_chk", 32'(chk_count), 32'd0);
    check("arst_err", 32'(err_count), 32'd0);
    check("arst_fev", 32'(first_err_valid), 32'd0);
    check("arst_fabc", 32'(first_err_abc), 32'd0);
    rst = 1'b0;
    tick();
    run_vec(3'b001, 1'b1, 1'b1);
    check("post_rst_chk", 32'(chk_count), 32'd1);
    check("post_rst_err", 32'(err_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/combi_response_checker.md
Name: combi_response_checker

Overview:
- Hardware response checker for the 3-input combinational circuit under test (inputs a, b, c; output y).
- An upstream vector source applies {a,b,c} to the DUT and, in the same cycle, hands the vector to this block over a valid/ready handshake.
- The block waits a fixed settle time, samples the DUT's y, and compares it with a parameterised truth table.
- It keeps check and error counts and records the first failing vector, for use in on-chip self-test and in benches.

Parameters:
- EXPECTED, 8'b1111_0010, expected y for each vector; bit index = {a,b,c} (e.g. EXPECTED[3'b001] is expected y for a=0,b=0,c=1).
- SETTLE, 4, clock cycles from vector acceptance to y sampling; legal range 1..255.
- CNT_W, 8, width of the check and error counters.

Ports:
- clk  input  1  clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous clear of counters and the first-error record; aborts any in-flight check.
- vec_valid  input  1  upstream presents a vector.
- vec_abc  input  3  vector {a,b,c} currently applied to the DUT.
- vec_ready  output  1  checker can accept a vector.
- y_in  input  1  DUT output y.
- check_done  output  1  one-cycle pulse: a comparison completed.
- check_pass  output  1  valid with check_done; 1 = y matched EXPECTED.
- chk_count  output  CNT_W  completed comparisons, saturating.
- err_count  output  CNT_W  failed comparisons, saturating.
- first_err_valid  output  1  a failure has been recorded since the last reset/clear.
- first_err_abc  output  3  vector of the first failure.
- first_err_y  output  1  y value observed at the first failure.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - vec_ready=1.
  - check_done, check_pass, chk_count, err_count, first_err_valid, first_err_abc and first_err_y all go to 0.
  - Settle counter goes to 0.
- FSM states:
  - IDLE: vec_ready=1.
  - WAIT: vec_ready=0.
- Accept:
  - accept = vec_valid & vec_ready & ~clear, sampled at rising edge T0.
  - On accept, latch vec_abc into abc_q, load the settle counter with SETTLE-1, and move IDLE→WAIT.
- WAIT:
  - The settle counter decrements each edge.
  - At the edge where the counter is 0 (edge T0+SETTLE), sample y_in and compare it with EXPECTED[abc_q], then return to IDLE.
- Result timing:
  - In the cycle after edge T0+SETTLE, check_done=1 and check_pass=(y_in==EXPECTED[abc_q]).
  - chk_count increments at that same edge; err_count increments there too on a mismatch.
  - vec_ready is 1 in that cycle, so back-to-back vectors are accepted every SETTLE+1 cycles.
  - check_done and check_pass are registered and are 0 in every other cycle.
- First error:
  - On the first mismatch while first_err_valid=0, set first_err_valid=1 and capture abc_q and the sampled y_in.
  - Later mismatches do not overwrite the record.
- Saturation: the counters hold at 2^CNT_W-1 and never wrap. chk_count stays ≥ err_count at all times.
- vec_abc and vec_valid are ignored in WAIT. Upstream must hold the vector on the DUT until check_done.
- clear:
  - Has priority over every other event.
  - Zeroes the counters and the first-error record, and forces IDLE.
  - No check_done is issued for an aborted check.
  - A vector presented in the same cycle as clear is not accepted.
- If clear coincides with the sampling edge, the result is discarded, nothing increments, and check_done stays 0 in the following cycle.
- Reset mid-WAIT: the check is lost and all outputs return to their reset values immediately, without waiting for a clock edge.

Test Plan:
- Default parameters: apply abc=000, 001, 100, 110 with y_in driven per EXPECTED (0,1,1,1) → 4 check_done pulses all with check_pass=1; chk_count=4, err_count=0, first_err_valid=0.
- Drive y_in=0 for abc=100, then y_in=1 for abc=000 → err_count=2; first_err_valid=1, first_err_abc=100, first_err_y=0, with no overwrite by the second failure.
- Latency, SETTLE=4: vec_valid accepted at edge 10 → y_in sampled at edge 14, check_done high in cycle 14–15, vec_ready low in cycles 10–14, and a second vector accepted at edge 15.
- Assert clear at edge 12 with the check in flight → no check_done, counters 0, vec_ready=1 at cycle 13; vec_valid held with clear is not accepted.
- CNT_W=2: run 5 failing checks → chk_count=3, err_count=3 (saturated, no wrap).
- Pulse rst asynchronously mid-WAIT, between edges → all outputs reach their reset values before the next edge; the next vector is then checked normally.
